spi_eeprom_sequencer: RTL
=========================

# spi_eeprom_sequencer

Controller that sits in front of the SPI master engine and turns byte-level EEPROM read/write requests from two requesters (Wishbone slave side "A", boot/config loader "B") into M25AA010A instruction sequences. It arbitrates round-robin between the requesters, issues READ directly, and for writes issues WREN, WRITE, then polls RDSR until the write-in-progress bit clears or a poll limit expires. The SPI engine owns MOSI/MISO/CSn/SCK; this block only drives its command interface.

## Interface
- POLL_MAX, 1000: maximum RDSR polls per write before error
- POLL_GAP, 8: idle clk cycles between consecutive RDSR polls
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_a / req_b  in  1  request, held high with fields stable until ack/err
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  7  EEPROM byte address (0..127)
- wdata_a / wdata_b  in  8  write byte
- ack_a / ack_b  out  1  one-cycle completion pulse
- err_a / err_b  out  1  one-cycle failure pulse (poll timeout)
- rdata  out  8  read byte, valid in the ack cycle, held until next read completes
- busy  out  1  high in every state except IDLE
- spi_cmd  out  32  {byte0[31:24], byte1[23:16], byte2[15:8], 6'b0, nbytes_m1[1:0]}
- spi_start  out  1  one-cycle pulse; spi_cmd valid in the same cycle
- spi_ack  in  1  one-cycle pulse from engine at end of transfer (CSn released)
- spi_rdata  in  8  last byte shifted in from MISO, valid with spi_ack

## Operation
- Opcodes: READ 0x03, WRITE 0x02, WREN 0x06, RDSR 0x05. Address byte = {1'b0, addr}.
- Transfers: WREN nbytes_m1=0; RDSR {0x05,0x00,0x00}, m1=1; READ {0x03,addr,0x00}, m1=2; WRITE {0x02,addr,wdata}, m1=2.
- FSM: IDLE, RD_CMD, RD_WAIT, WREN_CMD, WREN_WAIT, WR_CMD, WR_WAIT, POLL_CMD, POLL_WAIT, POLL_GAP, DONE.
- IDLE: if any req, grant per arbiter, latch we/addr/wdata/owner; go RD_CMD (we=0) or WREN_CMD (we=1).
- *_CMD: load spi_cmd, pulse spi_start, go matching *_WAIT. *_WAIT: hold until spi_ack.
- RD_WAIT+spi_ack: rdata<=spi_rdata, go DONE. WREN_WAIT -> WR_CMD. WR_WAIT -> POLL_CMD, poll count cleared.
- POLL_WAIT+spi_ack: count++; spi_rdata[0]=0 -> DONE; else count==POLL_MAX -> DONE with error; else POLL_GAP.
- POLL_GAP: count POLL_GAP cycles, then POLL_CMD.
- DONE: pulse ack_x (or err_x) of latched owner, flip arbiter priority to the other requester, go IDLE.
- Arbiter: both requests -> priority owner wins; after reset priority = A. Requests only sampled in IDLE.
- Requester dropping req mid-op: sequence still completes, pulse still issued.
- spi_ack outside a *_WAIT state: ignored.

## Timing
- Reset values: all outputs 0, spi_cmd 32'h0, state IDLE, priority A, counters 0.
- Reset mid-operation clears immediately; no ack/err issued; engine shares rst.
- req seen in IDLE at edge N -> spi_start at N+1. ack_x/err_x exactly one cycle after final spi_ack (DONE state).
- Requester must deassert req the cycle after ack/err; a still-high req in IDLE is a new request.
- Back-to-back: next grant earliest the cycle after DONE (IDLE one cycle minimum).
- spi_start never asserted while waiting for spi_ack.

## Structure
- Package spi_eeprom_pkg: opcode constants, nbytes_m1 codes, spi_cmd field positions, FSM state encoding.
- Sub-module spi_rr_arb2: 2-way round-robin arbiter (req_a, req_b, advance, grant_a, grant_b).

## Test plan
- Read: req_a, addr=0x15, engine returns 0xA5 -> spi_cmd=0x03150002, ack_a with rdata=0xA5 one cycle after spi_ack.
- Write: req_b, addr=0x7F, wdata=0x3C; status 0x01 twice then 0x00 -> cmds 0x06000000, 0x027F3C02, three 0x05000001 polls each POLL_GAP apart, ack_b.
- Poll timeout: POLL_MAX=4, status stuck 0x01 -> exactly 4 RDSR transfers, err_b pulse, no ack_b.
- Arbitration: req_a and req_b simultaneous from reset, both held -> A served first, then B; repeat -> A then B alternate.
- Reset mid-write in POLL_WAIT -> all outputs 0 next cycle, no ack; fresh read afterwards completes normally.
- With real M25AA010A model: write 0x5A to 0x10, read 0x10 -> rdata=0x5A.

Source files
------------

// File: rtl/spi_eeprom_pkg.sv
// spi_eeprom_pkg: opcodes, transfer lengths, command layout and FSM
// encoding shared by the EEPROM sequencer and its arbiter.
package spi_eeprom_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    localparam logic [1:0] NB_WREN = 2'd0;
    localparam logic [1:0] NB_RDSR = 2'd1;
    localparam logic [1:0] NB_READ = 2'd2;
    localparam logic [1:0] NB_WRIT = 2'd2;

    localparam int CMD_B0_LSB = 24;
    localparam int CMD_B1_LSB = 16;
    localparam int CMD_B2_LSB = 8;
    localparam int CMD_NB_LSB = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_WAIT,
        S_WREN_CMD,
        S_WREN_WAIT,
        S_WR_CMD,
        S_WR_WAIT,
        S_POLL_CMD,
        S_POLL_WAIT,
        S_POLL_GAP,
        S_DONE
    } state_e;

    function automatic logic [31:0] mk_cmd(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [1:0] m1
    );
        return (32'(b0) << CMD_B0_LSB) | (32'(b1) << CMD_B1_LSB)
             | (32'(b2) << CMD_B2_LSB) | (32'(m1) << CMD_NB_LSB);
    endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// spi_rr_arb2: two-way round-robin arbiter; after each completed
// operation priority moves to the requester that was not served.
module spi_rr_arb2
    import spi_eeprom_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    input  logic owner_b,
    output logic grant_a,
    output logic grant_b
);

    logic prio_b_q;
    logic prio_b_d;

    // next priority: hand it to the requester that just lost out
    always_comb begin
        prio_b_d = prio_b_q;
        if (advance) prio_b_d = ~owner_b;
    end

    // priority register, A after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prio_b_q <= 1'b0;
        else     prio_b_q <= prio_b_d;
    end

    // grant the sole requester, or the priority holder on contention
    always_comb begin
        grant_a = req_a && (!req_b || !prio_b_q);
        grant_b = req_b && (!req_a ||  prio_b_q);
    end

endmodule

// File: rtl/spi_eeprom_sequencer.sv
// spi_eeprom_sequencer: turns byte read/write requests from two requesters
// into M25AA010A READ / WREN+WRITE+RDSR-poll sequences on the SPI engine.
module spi_eeprom_sequencer
    import spi_eeprom_pkg::*;
#(
    parameter int POLL_MAX = 1000,
    parameter int POLL_GAP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        we_a,
    input  logic        we_b,
    input  logic [6:0]  addr_a,
    input  logic [6:0]  addr_b,
    input  logic [7:0]  wdata_a,
    input  logic [7:0]  wdata_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic        err_a,
    output logic        err_b,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [31:0] spi_cmd,
    output logic        spi_start,
    input  logic        spi_ack,
    input  logic [7:0]  spi_rdata
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = $clog2(POLL_GAP + 1);

    state_e         state_q, state_d;
    logic           owner_q, owner_d;
    logic           we_q, we_d;
    logic [6:0]     addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           err_q, err_d;
    logic [PW-1:0]  poll_q, poll_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           grant_a, grant_b;
    logic           advance;

    spi_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .req_b   (req_b),
        .advance (advance),
        .owner_b (owner_q),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    // sequencer next state, SPI command issue and completion pulses
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        poll_d    = poll_q;
        gap_d     = gap_q;
        spi_cmd   = 32'h0;
        spi_start = 1'b0;
        ack_a     = 1'b0;
        ack_b     = 1'b0;
        err_a     = 1'b0;
        err_b     = 1'b0;
        advance   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_a || grant_b) begin
                    owner_d = grant_b;
                    we_d    = grant_b ? we_b : we_a;
                    addr_d  = grant_b ? addr_b : addr_a;
                    wdata_d = grant_b ? wdata_b : wdata_a;
                    err_d   = 1'b0;
                    state_d = (grant_b ? we_b : we_a) ? S_WREN_CMD : S_RD_CMD;
                end
            end
            S_RD_CMD: begin
                spi_cmd   = mk_cmd(OP_READ, {1'b0, addr_q}, 8'h00, NB_READ);
                spi_start = 1'b1;
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (spi_ack) begin
                    rdata_d = spi_rdata;
                    state_d = S_DONE;
                end
            end
            S_WREN_CMD: begin
                spi_cmd   = mk_cmd(OP_WREN, 8'h00, 8'h00, NB_WREN);
                spi_start = 1'b1;
                state_d   = S_WREN_WAIT;
            end
            S_WREN_WAIT: begin
                if (spi_ack) state_d = S_WR_CMD;
            end
            S_WR_CMD: begin
                spi_cmd   = mk_cmd(OP_WRITE, {1'b0, addr_q}, wdata_q, NB_WRIT);
                spi_start = 1'b1;
                state_d   = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (spi_ack) begin
                    poll_d  = '0;
                    state_d = S_POLL_CMD;
                end
            end
            S_POLL_CMD: begin
                spi_cmd   = mk_cmd(OP_RDSR, 8'h00, 8'h00, NB_RDSR);
                spi_start = 1'b1;
                state_d   = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (spi_ack) begin
                    poll_d = poll_q + PW'(1);
                    if (!spi_rdata[0]) begin
                        state_d = S_DONE;
                    end else if (poll_q + PW'(1) == PW'(POLL_MAX)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        gap_d   = '0;
                        state_d = S_POLL_GAP;
                    end
                end
            end
            S_POLL_GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) state_d = S_POLL_CMD;
                else                            gap_d   = gap_q + GW'(1);
            end
            S_DONE: begin
                ack_a   = !owner_q && !err_q;
                ack_b   =  owner_q && !err_q;
                err_a   = !owner_q &&  err_q;
                err_b   =  owner_q &&  err_q;
                advance = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and request-context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            poll_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
        end
    end

    // read data and activity flag straight from the registers
    always_comb begin
        rdata = rdata_q;
        busy  = (state_q != S_IDLE);
    end

endmodule
